// File: rtl/triple_scheduler_if.sv
// triple_scheduler_if: requester, shared-unit and response signals of the triple scheduler
interface triple_scheduler_if #(
    parameter int NREQ = 4,
    parameter int A_W  = 4,
    parameter int R_W  = 6,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ-1:0]     req_ready;
    logic [A_W-1:0]      tri_a;
    logic [R_W-1:0]      tri_result;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [R_W-1:0]      resp_result;
    logic                resp_ready;
    logic                busy;
    modport master (
        input  req_valid, req_a, tri_result, resp_ready,
        output req_ready, tri_a, resp_valid, resp_id, resp_result, busy
    );
    modport slave (
        output req_valid, req_a, tri_result, resp_ready,
        input  req_ready, tri_a, resp_valid, resp_id, resp_result, busy
    );
endinterface

// File: rtl/triple_scheduler.sv
// triple_scheduler: round-robin sharing of one combinational 3*a unit among NREQ requesters
module triple_scheduler #(
    parameter int NREQ = 4,
    parameter int A_W  = 4,
    parameter int R_W  = 6,
    parameter int ID_W = 2
) (
    input logic clk,
    input logic rst,
    triple_scheduler_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_reg;
    logic [A_W-1:0]  op_reg;
    logic [R_W-1:0]  res_reg;
    logic [ID_W-1:0] gnt;
    logic            gnt_ok;
    logic [ID_W-1:0] nxt_ptr;
    // first requesting index at or after rr_ptr, wrapping; descending scan so the nearest wins
    always_comb begin
        gnt = '0;
        gnt_ok = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt = ID_W'((int'(rr_ptr) + k) % NREQ);
                gnt_ok = 1'b1;
            end
        end
    end
    assign nxt_ptr         = (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
    assign bus.req_ready   = (state == IDLE && gnt_ok) ? NREQ'(1) << gnt : '0;
    assign bus.tri_a       = op_reg;
    assign bus.resp_valid  = state == RESP;
    assign bus.resp_id     = (state == RESP) ? id_reg : '0;
    assign bus.resp_result = (state == RESP) ? res_reg : '0;
    assign bus.busy        = state != IDLE;
    // accept in IDLE, capture the shared unit's result in DRIVE, hold the response in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            op_reg  <= '0;
            id_reg  <= '0;
            res_reg <= '0;
        end else if (state == IDLE && gnt_ok) begin
            op_reg <= bus.req_a[gnt*A_W +: A_W];
            id_reg <= gnt;
            rr_ptr <= nxt_ptr;
            state  <= DRIVE;
        end else if (state == DRIVE) begin
            res_reg <= bus.tri_result;
            state   <= RESP;
        end else if (state == RESP && bus.resp_ready) begin
            state <= IDLE;
        end
    end
endmodule
